// File: rtl/ofdm_cp_remove.sv
// OFDM receive cyclic-prefix removal: drops CP_LEN prefix samples per symbol and queues whole N_FFT bodies for the FFT.
// Optional macro CPRM_DROP_CNT_EN adds a saturating drop_cnt output.
module ofdm_cp_remove #(
   parameter int N_FFT      = 64,
   parameter int CP_LEN     = 16,
   parameter int FIFO_DEPTH = 128,
   parameter int DW         = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          din_vld,
   input  logic          sym_start,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   input  logic          dout_rdy,
   output logic          dout_last,
   output logic [5:0]    dout_idx,
   output logic          sym_drop,
   output logic          sync_err
`ifdef CPRM_DROP_CNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = 7;
   localparam int EW = 1 + 6 + DW;
   localparam logic [CW-1:0]   LAST_CP   = CW'(CP_LEN - 1);
   localparam logic [CW-1:0]   LAST_BODY = CW'(N_FFT - 1);
   localparam logic [AW+1:0]   DEPTH_W   = (AW+2)'(FIFO_DEPTH);
   localparam logic [AW+1:0]   NFFT_W    = (AW+2)'(N_FFT);

   typedef enum logic [1:0] {IDLE = 2'd0, CP = 2'd1, DATA = 2'd2} state_t;

   state_t         state_r, state_n;
   logic [CW-1:0]  cnt_r, cnt_n;
   logic           keep_r, keep_n;
   logic           wr_vld_r, wr_vld_n;
   logic [EW-1:0]  wr_data_r, wr_data_n;
   logic           sym_drop_r, sym_drop_n;
   logic           sync_err_r, sync_err_n;

   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic [AW:0]    count_r;
   logic           push_s, pop_s, not_empty_s;
   logic [AW+1:0]  free_s;
   logic [EW-1:0]  head_s;

   assign not_empty_s = (count_r != {(AW+1){1'b0}});
   assign push_s      = wr_vld_r;
   assign pop_s       = not_empty_s & dout_rdy;
   // The staged write counts as occupied; a pop in this cycle counts as freed.
   assign free_s = DEPTH_W - {1'b0, count_r} - (AW+2)'(wr_vld_r) + (AW+2)'(pop_s);

   // FSM, counters, write stage and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CW{1'b0}};
         keep_r     <= 1'b0;
         wr_vld_r   <= 1'b0;
         wr_data_r  <= {EW{1'b0}};
         sym_drop_r <= 1'b0;
         sync_err_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         keep_r     <= keep_n;
         wr_vld_r   <= wr_vld_n;
         wr_data_r  <= wr_data_n;
         sym_drop_r <= sym_drop_n;
         sync_err_r <= sync_err_n;
      end
   end

   // Next-state: prefix skipping, body sequencing and whole-symbol admission
   always_comb begin
      state_n    = state_r;
      cnt_n      = cnt_r;
      keep_n     = keep_r;
      wr_vld_n   = 1'b0;
      wr_data_n  = wr_data_r;
      sym_drop_n = 1'b0;
      sync_err_n = 1'b0;
      case (state_r)
         IDLE: begin
            if (din_vld && sym_start) begin
               state_n = CP;
               cnt_n   = CW'(1);
            end else begin
               state_n = IDLE;
            end
         end
         CP: begin
            if (din_vld && sym_start) begin
               cnt_n = CW'(1);
            end else if (din_vld && (cnt_r == LAST_CP)) begin
               keep_n  = (free_s >= NFFT_W);
               state_n = DATA;
               cnt_n   = {CW{1'b0}};
            end else if (din_vld) begin
               cnt_n = cnt_r + CW'(1);
            end else begin
               cnt_n = cnt_r;
            end
         end
         DATA: begin
            if (din_vld) begin
               sync_err_n = sym_start;
               if (keep_r) begin
                  wr_vld_n  = 1'b1;
                  wr_data_n = {(cnt_r == LAST_BODY), cnt_r[5:0], din};
               end else begin
                  sym_drop_n = (cnt_r == {CW{1'b0}});
               end
               if (cnt_r == LAST_BODY) begin
                  state_n = CP;
                  cnt_n   = {CW{1'b0}};
               end else begin
                  cnt_n = cnt_r + CW'(1);
               end
            end else begin
               cnt_n = cnt_r;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = {CW{1'b0}};
         end
      endcase
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wr_ptr_r] <= wr_data_r;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_s    = mem[rd_ptr_r];
   assign dout_vld  = not_empty_s;
   assign dout      = not_empty_s ? head_s[DW-1:0] : {DW{1'b0}};
   assign dout_idx  = not_empty_s ? head_s[DW+5:DW] : 6'd0;
   assign dout_last = not_empty_s ? head_s[EW-1] : 1'b0;
   assign sym_drop  = sym_drop_r;
   assign sync_err  = sync_err_r;

`ifdef CPRM_DROP_CNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of discarded symbols
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_r <= 16'd0;
      end else if (sym_drop_n && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Directed bench for ofdm_cp_remove: a symbol-position model builds the expected body stream,
// a negedge monitor compares every handshake, and literal checks pin the model per test.
module tb_ofdm_cp_remove;
   localparam int N_FFT = 64;
   localparam int CP_LEN = 16;
   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic        din_vld, sym_start, dout_rdy;
   logic [15:0] dout;
   logic        dout_vld, dout_last, sym_drop, sync_err;
   logic [5:0]  dout_idx;
`ifdef CPRM_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   ofdm_cp_remove dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .sym_start(sym_start),
      .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_last(dout_last),
      .dout_idx(dout_idx), .sym_drop(sym_drop), .sync_err(sync_err)
`ifdef CPRM_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // model state: position of the next sample inside an 80-sample symbol, -1 when unsynchronised
   logic [22:0] exp_q[$];
   int mpos = -1;
   bit mkeep = 1'b0;
   int exp_drop, exp_err, got_drop, got_err, out_cnt, last_cnt, first_vld_cyc;
   logic [15:0] first_d, last_d;

   task automatic clear_stats();
      exp_drop = 0; exp_err = 0; got_drop = 0; got_err = 0;
      out_cnt = 0; last_cnt = 0; first_vld_cyc = -1; first_d = 16'd0; last_d = 16'd0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_vld) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               chk("dout", dout, exp_q[0][15:0]);
               chk("dout_idx", dout_idx, exp_q[0][21:16]);
               chk("dout_last", dout_last, exp_q[0][22]);
               if (dout_rdy) begin
                  void'(exp_q.pop_front());
                  out_cnt++;
                  if (out_cnt == 1) first_d = dout;
                  last_d = dout;
                  if (dout_last) last_cnt++;
               end
            end
         end
         if (sym_drop) got_drop++;
         if (sync_err) got_err++;
         if (din_vld) begin
            if (mpos < 0) begin
               if (sym_start) mpos = 1;
            end else if (mpos < CP_LEN) begin
               if (sym_start) mpos = 1;
               else begin
                  if (mpos == CP_LEN - 1) mkeep = (DEPTH - exp_q.size()) >= N_FFT;
                  mpos++;
               end
            end else begin
               if (sym_start) exp_err++;
               if (mkeep) exp_q.push_back({(mpos == CP_LEN + N_FFT - 1), 6'(mpos - CP_LEN), din});
               else if (mpos == CP_LEN) exp_drop++;
               mpos = (mpos == CP_LEN + N_FFT - 1) ? 0 : mpos + 1;
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic ss, input logic v);
      @(posedge clk); #1;
      din = d; sym_start = ss; din_vld = v;
   endtask

   task automatic model_reset();
      exp_q.delete(); mpos = -1; mkeep = 1'b0; clear_stats();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; din_vld = 1'b0; sym_start = 1'b0; din = 16'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      int n;
      @(posedge clk); #1;
      din_vld = 1'b0; sym_start = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); n++;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", exp_q.size(), 32'd0);
      chk("no_extra_vld", dout_vld, 32'd0);
      chk("drop_vs_model", got_drop, exp_drop);
      chk("err_vs_model", got_err, exp_err);
   endtask

   initial begin
      int in16_cyc;
      rst_n = 1'b0; din = 16'd0; din_vld = 1'b0; sym_start = 1'b0; dout_rdy = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_vld", dout_vld, 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_idx", dout_idx, 32'd0);
      chk("rst_last", dout_last, 32'd0);
      chk("rst_drop", sym_drop, 32'd0);
      chk("rst_err", sync_err, 32'd0);
      #1 rst_n = 1'b1;

      // 1) one symbol
      do_reset();
      in16_cyc = 0;
      for (int i = 0; i < 80; i++) begin
         send(16'(i), (i == 0), 1'b1);
         if (i == 16) in16_cyc = cyc;
      end
      drain();
      chk("t1_count", out_cnt, 32'd64);
      chk("t1_first", first_d, 32'd16);
      chk("t1_lastd", last_d, 32'd79);
      chk("t1_lasts", last_cnt, 32'd1);
      chk("t1_drop", got_drop, 32'd0);
      chk("t1_latency", first_vld_cyc - in16_cyc, 32'd2);

      // 2) two back-to-back symbols, one sym_start
      do_reset();
      for (int i = 0; i < 160; i++) send(16'(i), (i == 0), 1'b1);
      drain();
      chk("t2_count", out_cnt, 32'd128);
      chk("t2_lastd", last_d, 32'd159);
      chk("t2_lasts", last_cnt, 32'd2);

      // 3) same with gaps; sym_start without din_vld must be ignored
      do_reset();
      for (int i = 0; i < 160; i++) begin
         send(16'(i), (i == 0), 1'b1);
         send(16'hFFFF, 1'b1, 1'b0);
      end
      drain();
      chk("t3_count", out_cnt, 32'd128);
      chk("t3_first", first_d, 32'd16);
      chk("t3_lastd", last_d, 32'd159);
      chk("t3_lasts", last_cnt, 32'd2);

      // 4) backpressure: third symbol dropped
      do_reset();
      dout_rdy = 1'b0;
      for (int i = 0; i < 240; i++) send(16'(i), (i == 0), 1'b1);
      @(posedge clk); #1 din_vld = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t4_drop_pulses", got_drop, 32'd1);
      chk("t4_held_vld", dout_vld, 32'd1);
      chk("t4_held_dout", dout, 32'd16);
      chk("t4_held_idx", dout_idx, 32'd0);
`ifdef CPRM_DROP_CNT_EN
      chk("t4_drop_cnt", drop_cnt, 32'd1);
`endif
      dout_rdy = 1'b1;
      drain();
      chk("t4_count", out_cnt, 32'd128);
      chk("t4_lasts", last_cnt, 32'd2);
      chk("t4_lastd", last_d, 32'd159);

      // 5) restart in prefix, then stray sym_start in body idx 30
      do_reset();
      for (int i = 0; i < 90; i++) send(16'(i), (i == 0 || i == 10 || i == 56), 1'b1);
      drain();
      chk("t5_count", out_cnt, 32'd64);
      chk("t5_first", first_d, 32'd26);
      chk("t5_lastd", last_d, 32'd89);
      chk("t5_sync_err", got_err, 32'd1);
      chk("t5_drop", got_drop, 32'd0);

      // 6) asynchronous reset with entries queued, then a clean frame
      do_reset();
      for (int i = 0; i <= 56; i++) begin
         send(16'(i), (i == 0), 1'b1);
         if (i == 36) dout_rdy = 1'b0;
      end
      @(negedge clk);
      chk("t6_queued_vld", dout_vld, 32'd1);
      #2 rst_n = 1'b0; din_vld = 1'b0;
      model_reset();
      @(negedge clk);
      chk("t6_rst_vld", dout_vld, 32'd0);
      chk("t6_rst_dout", dout, 32'd0);
      chk("t6_rst_idx", dout_idx, 32'd0);
      chk("t6_rst_last", dout_last, 32'd0);
      #1 rst_n = 1'b1; dout_rdy = 1'b1;
      for (int i = 0; i < 80; i++) send(16'(1000 + i), (i == 0), 1'b1);
      drain();
      chk("t6_count", out_cnt, 32'd64);
      chk("t6_first", first_d, 32'd1016);
      chk("t6_lastd", last_d, 32'd1079);
      chk("t6_lasts", last_cnt, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
